// File: rtl/ram_data_fifo_rg.sv
// ram_data_fifo_rg: read-data buffer between the data-memory/external bus
// read port and the core's read-data mux. It queues up to DEPTH returned
// words and presents the head word on a registered data_out that stays frozen
// while the core is stalled. It also reports the fill level and a sticky
// overflow flag.
//
// Handshake: the producer offers a word with data_vld. The word is accepted
// when there is space, or when a pop frees a slot in the same cycle. The
// consumer takes the head word with rd_ack while data_rdy = 1 and
// cpuwait = 0. An offered word that cannot be accepted is dropped and
// recorded in ovf.
module ram_data_fifo_rg #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          cp2,
    input  logic          ireset,
    input  logic          cpuwait,
    input  logic [DW-1:0] data_in,
    input  logic          data_vld,
    input  logic          rd_ack,
    input  logic          ovf_clr,
    output logic [DW-1:0] data_out,
    output logic          data_rdy,
    output logic          full,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LEVEL_TWO  = (AW+1)'(2);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   level_next;
    logic          pop;
    logic          push;
    logic          drop;

    // Qualified requests. A push into a full queue is still accepted when a
    // pop frees the slot in the same cycle.
    assign full        = (level == LEVEL_FULL);
    assign pop         = rd_ack & data_rdy & ~cpuwait;
    assign push        = data_vld & (~full | pop);
    assign drop        = data_vld & full & ~pop;
    assign rd_ptr_next = rd_ptr + 1'b1;

    // Level arithmetic is in AW+1 bits. The push/pop qualifiers keep it
    // within 0..DEPTH.
    always_comb begin
        level_next = level + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Storage array. It has no reset because stale entries are never
    // presented.
    always_ff @(posedge cp2) begin
        if (!ireset && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, level, head register and overflow flag.
    always_ff @(posedge cp2) begin
        if (ireset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            data_out <= '0;
            data_rdy <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            level    <= level_next;
            data_rdy <= (level_next != '0);

            // The head word is loaded straight from data_in when the new word
            // becomes the head: either the queue is empty, or the last word is
            // popped in the same cycle. Otherwise a pop advances to the next
            // stored word. That word is already in the array because
            // level >= 2, and a concurrent push at wr_ptr never lands on it.
            if (push && (level == '0 || (pop && level == LEVEL_ONE))) begin
                data_out <= data_in;
            end else if (pop && level >= LEVEL_TWO) begin
                data_out <= mem[rd_ptr_next];
            end

            // A new drop takes priority over ovf_clr.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_data_fifo_rg.sv
// Directed testbench for ram_data_fifo_rg (DW=8, DEPTH=4, AW=2).
// Inputs change #1 after the rising edge, and outputs are checked at that same
// point, so each check reflects the edge that just occurred.
module tb_ram_data_fifo_rg;

    logic       cp2;
    logic       ireset;
    logic       cpuwait;
    logic [7:0] data_in;
    logic       data_vld;
    logic       rd_ack;
    logic       ovf_clr;
    logic [7:0] data_out;
    logic       data_rdy;
    logic       full;
    logic [2:0] level;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    ram_data_fifo_rg #(.DW(8), .DEPTH(4), .AW(2)) dut (
        .cp2      (cp2),
        .ireset   (ireset),
        .cpuwait  (cpuwait),
        .data_in  (data_in),
        .data_vld (data_vld),
        .rd_ack   (rd_ack),
        .ovf_clr  (ovf_clr),
        .data_out (data_out),
        .data_rdy (data_rdy),
        .full     (full),
        .level    (level),
        .ovf      (ovf)
    );

    // Clock generation.
    initial begin
        cp2 = 1'b0;
        forever #5 cp2 = ~cp2;
    end

    // Advance one clock edge and settle.
    task automatic step();
        @(posedge cp2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        data_in  = d;
        data_vld = 1'b1;
        step();
        data_vld = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_do,
                             input logic exp_rdy, input logic [2:0] exp_lvl);
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
        check({tag, "_dout"}, 32'(data_out), 32'(exp_do));
        check({tag, "_rdy"},  32'(data_rdy), 32'(exp_rdy));
        check({tag, "_lvl"},  32'(level),    32'(exp_lvl));
    endtask

    initial begin
        ireset   = 1'b1;
        cpuwait  = 1'b0;
        data_in  = 8'h00;
        data_vld = 1'b0;
        rd_ack   = 1'b0;
        ovf_clr  = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            cpuwait  = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom_range(0, 255));
            data_vld = 1'($urandom_range(0, 1));
            rd_ack   = 1'($urandom_range(0, 1));
            ovf_clr  = 1'($urandom_range(0, 1));
            step();
        end
        check("rst_dout", 32'(data_out), 32'h00);
        check("rst_lvl",  32'(level),    32'd0);
        check("rst_rdy",  32'(data_rdy), 32'd0);
        check("rst_full", 32'(full),     32'd0);
        check("rst_ovf",  32'(ovf),      32'd0);
        ireset   = 1'b0;
        cpuwait  = 1'b0;
        data_vld = 1'b0;
        rd_ack   = 1'b0;
        ovf_clr  = 1'b0;
        step();

        // 2: latency of one cycle, no combinational bypass
        data_in  = 8'hA5;
        data_vld = 1'b1;
        check("nobypass_rdy",  32'(data_rdy), 32'd0);
        check("nobypass_dout", 32'(data_out), 32'h00);
        step();
        data_vld = 1'b0;
        check("lat_rdy",  32'(data_rdy), 32'd1);
        check("lat_dout", 32'(data_out), 32'hA5);
        check("lat_lvl",  32'(level),    32'd1);
        pop_check("lat_pop", 8'hA5, 1'b0, 3'd0);
        pop_check("underflow", 8'hA5, 1'b0, 3'd0);

        // 3: order and pointer wrap
        push(8'h11);
        check("ord_first", 32'(data_out), 32'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("ord_full", 32'(full),     32'd1);
        check("ord_lvl4", 32'(level),    32'd4);
        check("ord_head", 32'(data_out), 32'h11);
        pop_check("ord_p1", 8'h22, 1'b1, 3'd3);
        pop_check("ord_p2", 8'h33, 1'b1, 3'd2);
        check("ord_notfull", 32'(full), 32'd0);
        push(8'h55);
        push(8'h66);
        check("ord_full2", 32'(full),     32'd1);
        check("ord_head2", 32'(data_out), 32'h33);
        pop_check("ord_p3", 8'h44, 1'b1, 3'd3);
        pop_check("ord_p4", 8'h55, 1'b1, 3'd2);
        pop_check("ord_p5", 8'h66, 1'b1, 3'd1);
        pop_check("ord_p6", 8'h66, 1'b0, 3'd0);

        // 4: cpuwait freezes the head while pushes continue
        push(8'h11);
        push(8'h22);
        cpuwait = 1'b1;
        rd_ack  = 1'b1;
        step();
        check("wait_c1_dout", 32'(data_out), 32'h11);
        check("wait_c1_lvl",  32'(level),    32'd2);
        data_in  = 8'h33;
        data_vld = 1'b1;
        step();
        data_vld = 1'b0;
        check("wait_c2_dout", 32'(data_out), 32'h11);
        check("wait_c2_lvl",  32'(level),    32'd3);
        step();
        check("wait_c3_dout", 32'(data_out), 32'h11);
        check("wait_c3_lvl",  32'(level),    32'd3);
        cpuwait = 1'b0;
        pop_check("wait_r1", 8'h22, 1'b1, 3'd2);
        pop_check("wait_r2", 8'h33, 1'b1, 3'd1);
        pop_check("wait_r3", 8'h33, 1'b0, 3'd0);

        // 5: full corners and overflow
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h77);
        check("drop_ovf",  32'(ovf),      32'd1);
        check("drop_lvl",  32'(level),    32'd4);
        check("drop_dout", 32'(data_out), 32'h11);
        step();
        check("ovf_sticky", 32'(ovf), 32'd1);
        data_in  = 8'h88;
        data_vld = 1'b1;
        rd_ack   = 1'b1;
        step();
        data_vld = 1'b0;
        rd_ack   = 1'b0;
        check("fullpp_lvl",  32'(level),    32'd4);
        check("fullpp_dout", 32'(data_out), 32'h22);
        data_in  = 8'h99;
        data_vld = 1'b1;
        ovf_clr  = 1'b1;
        step();
        data_vld = 1'b0;
        ovf_clr  = 1'b0;
        check("clr_vs_drop", 32'(ovf),   32'd1);
        check("clr_vs_lvl",  32'(level), 32'd4);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        pop_check("full_p1", 8'h33, 1'b1, 3'd3);
        pop_check("full_p2", 8'h44, 1'b1, 3'd2);
        pop_check("full_p3", 8'h88, 1'b1, 3'd1);
        pop_check("full_p4", 8'h88, 1'b0, 3'd0);

        // 6: reset mid-burst, with a push offered during reset
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("pre_rst_lvl", 32'(level), 32'd3);
        ireset   = 1'b1;
        data_in  = 8'hEE;
        data_vld = 1'b1;
        step();
        ireset   = 1'b0;
        data_vld = 1'b0;
        check("mid_rst_dout", 32'(data_out), 32'h00);
        check("mid_rst_lvl",  32'(level),    32'd0);
        check("mid_rst_rdy",  32'(data_rdy), 32'd0);
        check("mid_rst_full", 32'(full),     32'd0);
        check("mid_rst_ovf",  32'(ovf),      32'd0);
        push(8'hC3);
        check("post_rst_dout", 32'(data_out), 32'hC3);
        check("post_rst_lvl",  32'(level),    32'd1);
        check("post_rst_rdy",  32'(data_rdy), 32'd1);

        // Pop of the last word with a simultaneous push
        data_in  = 8'hD4;
        data_vld = 1'b1;
        rd_ack   = 1'b1;
        step();
        data_vld = 1'b0;
        rd_ack   = 1'b0;
        check("l1pp_dout", 32'(data_out), 32'hD4);
        check("l1pp_rdy",  32'(data_rdy), 32'd1);
        check("l1pp_lvl",  32'(level),    32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
